// File: rtl/fp_stream_accum.sv
// Purpose: running-sum front-end for the combinational FP32 adder, emitting one sum/count/overflow result per frame.
// Latency: acc updates on the accepting edge; out_valid rises one cycle after the last beat is accepted.
// Backpressure: in_ready is low while a result waits; DONE holds indefinitely until out_ready.
module fp_stream_accum #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  state_t          state_q, state_d;
  fp32_t           acc_q, acc_d;
  fp32_t           op, sum;
  logic [CNT_W-1:0] cnt_q;
  logic            ovf_q;
  logic            ovf_hit;
  logic            accept;
  logic            out_fire;
  logic            op_flushed;
  logic            acc_is_zero;
  logic            adder_path;

  // Adder sees the registered sum and the live operand; no pipeline stage here.
  assign op    = fp32_t'(in_data);
  assign sum   = fp32_t'(add_o);
  assign add_a = acc_q;
  assign add_b = in_data;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // The adder always assumes a hidden 1, so zero/denormal operands are dropped
  // and a zero accumulator is loaded directly instead of going through the adder.
  assign op_flushed  = (op.exp == 8'h00);
  assign acc_is_zero = (acc_q[30:0] == 31'd0);
  assign adder_path  = !op_flushed && !acc_is_zero;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; the result handshake and a new beat never share a cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Next accumulator value and overflow detection for the current beat.
  always_comb begin
    acc_d   = acc_q;
    ovf_hit = 1'b0;
    if (op_flushed) begin
      acc_d = acc_q;
    end else if (acc_is_zero) begin
      acc_d = op;
    end else if (sum.exp == 8'h00) begin
      // Adder encodes exact cancellation with a zero exponent; normalise to +0.
      acc_d = fp32_t'(32'h0000_0000);
    end else begin
      acc_d = sum;
    end

    if (op.exp == 8'hFF) begin
      ovf_hit = 1'b1;
    end
    if (adder_path && (sum.exp == 8'hFF)) begin
      ovf_hit = 1'b1;
    end
    // Same-sign addition can never shrink the exponent unless it wrapped past 255.
    if (!op_flushed && (acc_q.sign == op.sign) && (sum.exp < acc_q.exp)) begin
      ovf_hit = 1'b1;
    end
  end

  // Frame state: accumulate on accepted beats, clear when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= fp32_t'(32'h0000_0000);
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (out_fire) begin
      acc_q <= fp32_t'(32'h0000_0000);
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (ovf_hit) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Result fields come straight from the frame registers, which are frozen in DONE.
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fp_stream_accum.sv
// Directed bench for fp_stream_accum with a behavioural FP32 adder model
// standing in for the team adder (hidden bit always 1, 8-bit exponent wrap).
module tb_fp_stream_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] add_a, add_b, add_o, out_data;
  logic [15:0] out_count;

  logic        in_valid2, in_last2, out_ready2;
  logic [31:0] in_data2;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [31:0] add_a2, add_b2, add_o2, out_data2;
  logic [1:0]  out_count2;

  int vectors;
  int miscompares;

  // Truncating FP32 adder model; cancellation returns an all-zero word.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [24:0] mx, my, s;
    logic [7:0]  e, d;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    e  = x[30:23];
    d  = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    my = (d > 8'd24) ? 25'd0 : (my >> d);
    if (x[31] == y[31]) begin
      s = mx + my;
      if (s[24]) begin
        s = s >> 1;
        e = e + 8'd1;
      end
    end else begin
      s = mx - my;
      if (s == 25'd0) return 32'h0;
      for (int i = 0; i < 24; i++) begin
        if (!s[23]) begin
          s = s << 1;
          e = e - 8'd1;
        end
      end
    end
    return {x[31], e, s[22:0]};
  endfunction

  assign add_o  = fp_add(add_a, add_b);
  assign add_o2 = fp_add(add_a2, add_b2);

  fp_stream_accum #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  fp_stream_accum #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .add_a(add_a2), .add_b(add_b2), .add_o(add_o2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_count(out_count2), .out_ovf(out_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the beat.
  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the negedge after the last accept: check result, then take it.
  task automatic take(input string tag, input logic [31:0] d, input logic [15:0] c, input logic o);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"},  out_data, d);
    chk({tag, ".count"}, {16'd0, out_count}, {16'd0, c});
    chk({tag, ".ovf"},   {31'd0, out_ovf}, {31'd0, o});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0; in_last  = 1'b0; in_data  = 32'h0; out_ready  = 1'b0;
    in_valid2  = 1'b0; in_last2 = 1'b0; in_data2 = 32'h0; out_ready2 = 1'b0;
    #1;
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data",  out_data, 32'h0);
    chk("rst.out_count", {16'd0, out_count}, 32'd0);
    chk("rst.out_ovf",   {31'd0, out_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0 = 3.0
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b1);
    take("f1", 32'h4040_0000, 16'd2, 1'b0);

    // 1.0 - 1.0 cancels to zero, then 2.0 is bypass-loaded
    beat(32'h3F80_0000, 1'b0);
    beat(32'hBF80_0000, 1'b0);
    chk("f2.cancel", out_data, 32'h0);
    beat(32'h4000_0000, 1'b1);
    take("f2", 32'h4000_0000, 16'd3, 1'b0);

    // zero is flushed but counted
    beat(32'h0000_0000, 1'b0);
    beat(32'h3FC0_0000, 1'b0);
    beat(32'h3F00_0000, 1'b1);
    take("f3", 32'h4000_0000, 16'd3, 1'b0);

    // single flushed beat: result 0, count 1
    beat(32'h0000_0000, 1'b1);
    take("f4", 32'h0000_0000, 16'd1, 1'b0);

    // exponent overflow, then 5 cycles of backpressure with in_valid ignored
    beat(32'h7F00_0000, 1'b0);
    beat(32'h7F00_0000, 1'b1);
    chk("f5.ovf", {31'd0, out_ovf}, 32'd1);
    in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.data",  out_data, 32'h7F80_0000);
      chk("bp.ready", {31'd0, in_ready}, 32'd0);
      chk("bp.count", {16'd0, out_count}, 32'd2);
    end
    // handshake with in_valid still high: beat must wait one cycle
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs.valid", {31'd0, out_valid}, 32'd0);
    chk("hs.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    take("f6", 32'h3F80_0000, 16'd1, 1'b0);

    // reset mid-frame
    beat(32'h3F80_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("mrst.out_data",  out_data, 32'h0);
    chk("mrst.out_count", {16'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(32'h4000_0000, 1'b1);
    take("f7", 32'h4000_0000, 16'd1, 1'b0);

    // CNT_W=2 instance: five 1.0 beats, count saturates at 3
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 32'h3F80_0000;
      in_last2  = (i == 4);
      @(negedge clk);
    end
    in_valid2 = 1'b0; in_last2 = 1'b0;
    chk("sat.valid", {31'd0, out_valid2}, 32'd1);
    chk("sat.data",  out_data2, 32'h40A0_0000);
    chk("sat.count", {30'd0, out_count2}, 32'd3);
    chk("sat.ovf",   {31'd0, out_ovf2}, 32'd0);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk("sat.idle", {31'd0, out_valid2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
